hc_mmio_rd_responder: RTL and testbench

Answers host MMIO read requests for the HardCloud CSR space: DFH/AFU ID, DSM base, control word, and per-buffer address/size. Also serves a status word and a cycle counter that the block maintains itself. It sits beside the MMIO write decoder on CCI-P channel c0 and drives every MMIO read response on channel c2. Together the two blocks give the host full read-back of everything it can write.

---
 rtl/hc_mmio_rd_responder.sv | 174 +++++++++++++++++
 tb/tb_hc_mmio_rd_responder.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hc_mmio_rd_responder.sv
// hc_mmio_rd_responder: serves host MMIO reads of the HardCloud CSR space
// (DFH, AFU ID, STATUS, cycle count, DSM base, control, buffer descriptors).
// Ports:
//   clk, reset_n        pClk, async active-low reset
//   rx_mmio_rd_valid    c0 MMIO read request strobe
//   rx_mmio_address     c0 dword address
//   rx_mmio_length      c0 length: 0 = 4B, 1 = 8B, 2 = 64B
//   rx_mmio_tid         c0 transaction ID
//   dsm_base, control   live CSR values from the write decoder
//   buffers             packed {addr[63:0], size[31:0]} per descriptor
//   tx_mmio_rd_valid    c2 MMIO read response strobe
//   tx_mmio_tid         c2 transaction ID
//   tx_mmio_data        c2 response data
module hc_mmio_rd_responder #(
   parameter logic [63:0] AFU_ID_L       = 64'h0,
   parameter logic [63:0] AFU_ID_H       = 64'h0,
   parameter int          HC_BUFFER_SIZE = 2,
   parameter logic [15:0] HC_BUFFER_BASE = 16'h120
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         rx_mmio_rd_valid,
   input  logic [15:0]                  rx_mmio_address,
   input  logic [1:0]                   rx_mmio_length,
   input  logic [8:0]                   rx_mmio_tid,
   input  logic [63:0]                  dsm_base,
   input  logic [31:0]                  control,
   input  logic [HC_BUFFER_SIZE*96-1:0] buffers,
   output logic                         tx_mmio_rd_valid,
   output logic [8:0]                   tx_mmio_tid,
   output logic [63:0]                  tx_mmio_data
);

   localparam logic [63:0] DFH =
      {4'h1, 8'h0, 4'h0, 7'h0, 1'b1, 16'h0, 24'h0};
   // qword index of descriptor 0 within the claimed 1 KB window
   localparam logic [6:0] BUF_Q = HC_BUFFER_BASE[9:3];

   logic        w_claim;
   logic        w_running;
   logic        w_clear;
   logic [63:0] w_status;
   logic [63:0] w_sel;
   logic [63:0] w_fmt;

   // request capture register
   logic        r_req_valid;
   logic [8:0]  r_req_tid;
   logic [1:0]  r_req_len;
   logic [7:0]  r_req_addr;

   // stage 1: decoded register snapshot
   logic        r_s1_valid;
   logic [8:0]  r_s1_tid;
   logic [1:0]  r_s1_len;
   logic        r_s1_hi;
   logic [63:0] r_s1_data;

   // status state
   logic [63:0] r_cycle_count;
   logic [31:0] r_reads_served;
   logic [31:0] r_prev_ctrl;
   logic        r_done;
   logic        r_error;

   assign w_claim   = rx_mmio_rd_valid && (rx_mmio_address[15:8] == 8'h0);
   assign w_running = (control == 32'h3);
   assign w_clear   = (control == 32'h0);
   assign w_status  = {r_reads_served, 29'h0, r_error, r_done, w_running};

   always_comb begin
      w_sel = 64'h0;
      case (r_req_addr[7:1])
         7'h00:   w_sel = DFH;
         7'h01:   w_sel = AFU_ID_L;
         7'h02:   w_sel = AFU_ID_H;
         7'h20:   w_sel = w_status;
         7'h21:   w_sel = r_cycle_count;
         7'h22:   w_sel = dsm_base;
         7'h23:   w_sel = {32'h0, control};
         default: w_sel = 64'h0;
      endcase
      for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
         if (r_req_addr[7:1] == BUF_Q + 7'(2 * i))
            w_sel = buffers[i*96+32 +: 64];
         if (r_req_addr[7:1] == BUF_Q + 7'(2 * i + 1))
            w_sel = {32'h0, buffers[i*96 +: 32]};
      end
   end

   always_comb begin
      w_fmt = 64'h0;
      case (r_s1_len)
         2'd1:    w_fmt = r_s1_data;
         2'd0:    w_fmt = r_s1_hi ? {32'h0, r_s1_data[63:32]}
                                  : {32'h0, r_s1_data[31:0]};
         default: w_fmt = 64'h0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_req_valid <= 1'b0;
         r_req_tid   <= 9'h0;
         r_req_len   <= 2'd0;
         r_req_addr  <= 8'h0;
      end else begin
         r_req_valid <= w_claim;
         // unclaimed requests leave no trace in the pipeline
         if (w_claim) begin
            r_req_tid  <= rx_mmio_tid;
            r_req_len  <= rx_mmio_length;
            r_req_addr <= rx_mmio_address[7:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_s1_tid   <= 9'h0;
         r_s1_len   <= 2'd0;
         r_s1_hi    <= 1'b0;
         r_s1_data  <= 64'h0;
      end else begin
         r_s1_valid <= r_req_valid;
         r_s1_tid   <= r_req_tid;
         r_s1_len   <= r_req_len;
         r_s1_hi    <= r_req_addr[0];
         r_s1_data  <= w_sel;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_mmio_rd_valid <= 1'b0;
         tx_mmio_tid      <= 9'h0;
         tx_mmio_data     <= 64'h0;
      end else begin
         tx_mmio_rd_valid <= r_s1_valid;
         tx_mmio_tid      <= r_s1_valid ? r_s1_tid : 9'h0;
         tx_mmio_data     <= r_s1_valid ? w_fmt : 64'h0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cycle_count  <= 64'h0;
         r_reads_served <= 32'h0;
         r_prev_ctrl    <= 32'h0;
         r_done         <= 1'b0;
         r_error        <= 1'b0;
      end else begin
         r_prev_ctrl <= control;
         // a zero control word clears everything, beating any set event
         if (w_clear) begin
            r_cycle_count  <= 64'h0;
            r_reads_served <= 32'h0;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
         end else begin
            if (w_running)
               r_cycle_count <= r_cycle_count + 64'd1;
            if (tx_mmio_rd_valid)
               r_reads_served <= r_reads_served + 32'd1;
            if (r_prev_ctrl == 32'h3 && control == 32'h7)
               r_done <= 1'b1;
            if (r_req_valid && r_req_len == 2'd2)
               r_error <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// tb_hc_mmio_rd_responder: table vectors, directed corner sequences and
// random traffic against a timeline model of the MMIO read responder.
module tb_hc_mmio_rd_responder;

   localparam logic [63:0] ID_L = 64'h1122_3344_5566_7788;
   localparam logic [63:0] ID_H = 64'h99AA_BBCC_DDEE_FF00;
   localparam int          NB   = 2;
   localparam logic [63:0] DFH  = 64'h1000_0100_0000_0000;

   logic           clk = 1'b0;
   logic           reset_n;
   logic           rx_v;
   logic [15:0]    rx_addr;
   logic [1:0]     rx_len;
   logic [8:0]     rx_tid;
   logic [63:0]    dsm;
   logic [31:0]    control;
   logic [NB*96-1:0] bufs;
   logic           tx_v;
   logic [8:0]     tx_tid;
   logic [63:0]    tx_data;

   always #5 clk = ~clk;

   hc_mmio_rd_responder #(
      .AFU_ID_L(ID_L),
      .AFU_ID_H(ID_H),
      .HC_BUFFER_SIZE(NB),
      .HC_BUFFER_BASE(16'h120)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .rx_mmio_rd_valid(rx_v),
      .rx_mmio_address(rx_addr),
      .rx_mmio_length(rx_len),
      .rx_mmio_tid(rx_tid),
      .dsm_base(dsm),
      .control(control),
      .buffers(bufs),
      .tx_mmio_rd_valid(tx_v),
      .tx_mmio_tid(tx_tid),
      .tx_mmio_data(tx_data)
   );

   typedef struct {
      longint      due;
      logic [8:0]  tid;
      logic [63:0] data;
   } exp_t;

   typedef struct {
      logic [15:0] dw;
      logic [1:0]  len;
      logic [63:0] exp;
   } vec_t;

   exp_t        expq[$];
   longint      edge_n = 0;
   logic [63:0] m_cc;
   logic [31:0] m_rs;
   logic [31:0] m_prev;
   bit          m_done, m_err, m_outv;
   bit          a_v;
   logic [8:0]  a_tid;
   logic [1:0]  a_len;
   logic [15:0] a_addr;
   int          n_run = 0;
   int          n_fail = 0;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // register value seen by a read at dword dw, from the register map
   function automatic logic [63:0] m_reg(input logic [15:0] dw);
      int b = int'(dw) / 2 * 8;
      int off;
      if (b == 0) return DFH;
      if (b == 8) return ID_L;
      if (b == 16) return ID_H;
      if (b == 'h100)
         return {m_rs, 29'h0, m_err, m_done, control == 32'h3};
      if (b == 'h108) return m_cc;
      if (b == 'h110) return dsm;
      if (b == 'h118) return {32'h0, control};
      if (b >= 'h120 && b < 'h120 + 16 * NB) begin
         off = b - 'h120;
         if (off % 16 == 0) return bufs[(off/16)*96+32 +: 64];
         return {32'h0, bufs[(off/16)*96 +: 32]};
      end
      return 64'h0;
   endfunction

   function automatic logic [63:0] m_resp(input logic [15:0] dw,
                                          input logic [1:0] len);
      logic [63:0] r = m_reg(dw);
      if (len == 2'd1) return r;
      if (len == 2'd0) return dw[0] ? {32'h0, r[63:32]} : {32'h0, r[31:0]};
      return 64'h0;
   endfunction

   task automatic model_clear();
      expq.delete();
      m_cc = 0; m_rs = 0; m_prev = 0;
      m_done = 0; m_err = 0; m_outv = 0; a_v = 0;
   endtask

   // one rising edge: request from the previous edge is snapshotted now
   task automatic model_edge();
      if (a_v)
         expq.push_back('{edge_n + 1, a_tid, m_resp(a_addr, a_len)});
      if (control == 32'h0) begin
         m_cc = 0; m_rs = 0; m_done = 0; m_err = 0;
      end else begin
         if (control == 32'h3) m_cc++;
         if (m_outv) m_rs++;
         if (m_prev == 32'h3 && control == 32'h7) m_done = 1;
         if (a_v && a_len == 2'd2) m_err = 1;
      end
      m_prev = control;
      a_v    = rx_v && (rx_addr < 16'h100);
      a_tid  = rx_tid;
      a_len  = rx_len;
      a_addr = rx_addr;
   endtask

   task automatic step(input bit v, input logic [15:0] a,
                       input logic [1:0] len, input logic [8:0] tid);
      exp_t e;
      rx_v = v; rx_addr = a; rx_len = len; rx_tid = tid;
      @(posedge clk);
      edge_n++;
      model_edge();
      #1;
      if (expq.size() != 0 && expq[0].due == edge_n) begin
         e = expq.pop_front();
         chk("resp", {tx_v, tx_tid, tx_data}, {1'b1, e.tid, e.data});
         m_outv = 1;
      end else begin
         chk("idle", {tx_v, tx_tid, tx_data}, 0);
         m_outv = 0;
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 16'h0, 2'd0, 9'h0);
   endtask

   // issue one read and return the response data two edges later
   task automatic rd(input logic [15:0] dw, input logic [1:0] len,
                     input logic [8:0] tid, output logic [63:0] d);
      step(1, dw, len, tid);
      idle(2);
      chk("rd_valid", {tx_v, tx_tid}, {1'b1, tid});
      d = tx_data;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_out", {tx_v, tx_tid, tx_data}, 0);
      model_clear();
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
   endtask

   vec_t        vt[17];
   logic [63:0] d;
   logic [31:0] picks[5];
   bit          ov[8];
   logic [8:0]  ot[8];
   int          seen;

   initial begin
      vt[0]  = '{16'h002, 2'd1, ID_L};
      vt[1]  = '{16'h004, 2'd1, ID_H};
      vt[2]  = '{16'h000, 2'd1, DFH};
      vt[3]  = '{16'h001, 2'd0, 64'h1000_0100};
      vt[4]  = '{16'h044, 2'd0, 64'h0123_4567};
      vt[5]  = '{16'h045, 2'd0, 64'hDEAD_BEEF};
      vt[6]  = '{16'h044, 2'd1, 64'hDEAD_BEEF_0123_4567};
      vt[7]  = '{16'h046, 2'd1, 64'h5};
      vt[8]  = '{16'h048, 2'd1, 64'hA0A0_0000_1234_0000};
      vt[9]  = '{16'h04A, 2'd1, 64'h1000};
      vt[10] = '{16'h04C, 2'd1, 64'hB1B1_0000_5678_0000};
      vt[11] = '{16'h04E, 2'd1, 64'h2000};
      vt[12] = '{16'h04D, 2'd0, 64'hB1B1_0000};
      vt[13] = '{16'h050, 2'd1, 64'h0};
      vt[14] = '{16'h00C, 2'd1, 64'h0};
      vt[15] = '{16'h0FF, 2'd0, 64'h0};
      vt[16] = '{16'h047, 2'd0, 64'h0};
      picks = '{32'h0, 32'h3, 32'h7, 32'h5, 32'h3};

      reset_n = 1'b0;
      rx_v = 0; rx_addr = 0; rx_len = 0; rx_tid = 0;
      dsm = 64'hDEAD_BEEF_0123_4567;
      control = 32'h5;
      bufs = {64'hB1B1_0000_5678_0000, 32'h2000,
              64'hA0A0_0000_1234_0000, 32'h1000};
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk("reset", {tx_v, tx_tid, tx_data}, 0);
      reset_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         step(1, vt[i].dw, vt[i].len, 9'(i + 'h15));
         idle(2);
         chk($sformatf("vec%0d", i), {tx_v, tx_tid, tx_data},
             {1'b1, 9'(i + 'h15), vt[i].exp});
         idle(1);
         chk("vec_gap", tx_v, 0);
      end

      // unclaimed addresses: no response at all
      seen = 0;
      step(1, 16'h100, 2'd1, 9'h3C);
      step(1, 16'hFFFF, 2'd0, 9'h3D);
      for (int k = 0; k < 10; k++) begin
         idle(1);
         if (tx_v) seen++;
      end
      chk("oor_none", seen, 0);

      // back-to-back ordering and reads_served
      control = 32'h0;
      idle(1);
      control = 32'h5;
      for (int k = 0; k < 8; k++) begin
         if (k < 4) step(1, 16'h002, 2'd1, 9'(k + 1));
         else idle(1);
         ov[k] = tx_v;
         ot[k] = tx_tid;
      end
      for (int k = 0; k < 8; k++)
         chk($sformatf("b2b%0d", k), {ov[k], ot[k]},
             {k >= 2 && k <= 5, (k >= 2 && k <= 5) ? 9'(k - 1) : 9'h0});
      rd(16'h040, 2'd1, 9'h0A, d);
      chk("status_rs4", d, 64'h0000_0004_0000_0000);

      // cycle counter, running and done
      control = 32'h3;
      rd(16'h040, 2'd0, 9'h0B, d);
      chk("running", d, 64'h1);
      control = 32'h0;
      idle(1);
      control = 32'h3;
      idle(100);
      control = 32'h7;
      rd(16'h042, 2'd1, 9'h21, d);
      chk("cycles100", d, 64'd100);
      rd(16'h040, 2'd1, 9'h22, d);
      chk("status_done", d, 64'h0000_0001_0000_0002);
      control = 32'h0;
      rd(16'h042, 2'd1, 9'h23, d);
      chk("cycles_clr", d, 64'h0);
      rd(16'h040, 2'd1, 9'h24, d);
      chk("status_clr", d, 64'h0);

      // 64B read: zero data, sticky error, clear wins
      control = 32'h5;
      rd(16'h000, 2'd2, 9'h2A, d);
      chk("len2_data", d, 64'h0);
      rd(16'h040, 2'd0, 9'h2B, d);
      chk("err_set", d, 64'h4);
      control = 32'h0;
      step(1, 16'h000, 2'd2, 9'h2C);
      idle(3);
      control = 32'h5;
      rd(16'h040, 2'd0, 9'h2D, d);
      chk("err_clr_wins", d, 64'h0);

      // reset with a response on the outputs and one in stage 1
      step(1, 16'h002, 2'd1, 9'h44);
      step(1, 16'h004, 2'd1, 9'h45);
      idle(1);
      chk("pre_rst_v", {tx_v, tx_tid}, {1'b1, 9'h44});
      do_reset();
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         idle(1);
         if (tx_v) seen++;
      end
      chk("rst_drop", seen, 0);

      // random traffic against the model
      for (int k = 0; k < 800; k++) begin
         if ($urandom_range(0, 7) == 0) control = picks[$urandom_range(0, 4)];
         if ($urandom_range(0, 31) == 0) dsm = {$urandom, $urandom};
         if ($urandom_range(0, 63) == 0)
            bufs = {$urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom};
         step($urandom_range(0, 9) < 6,
              $urandom_range(0, 7) == 0 ? 16'($urandom)
                                        : 16'($urandom_range(0, 'h5F)),
              $urandom_range(0, 5) == 0 ? 2'd2 : 2'($urandom_range(0, 1)),
              9'($urandom));
      end
      idle(4);
      chk("drain", expq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
